tlul_buffered_bridge: RTL and testbench

- Parametrised TL-UL master-to-slave bridge. Replaces the zero-latency combinational pass-through with registered FIFOs on channel A and channel D.
- Adds an outstanding-request limiter, an outstanding count output and an idle indication.
- Sits between a TL-UL host port and a device port to cut timing paths and bound in-flight requests.

---
 rtl/tlul_pkg.sv | 41 ++++
 rtl/tlul_fifo.sv | 59 +++++
 rtl/tlul_buffered_bridge.sv | 182 ++++++++++++++++++
 tb/tb_tlul_buffered_bridge.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_pkg.sv
// tlul_pkg: shared TL-UL beat types, default widths and opcode encodings (rev 1.0).
`default_nettype none

package tlul_pkg;

  localparam int TLUL_AW  = 32;
  localparam int TLUL_DW  = 32;
  localparam int TLUL_AIW = 8;
  localparam int TLUL_DIW = 1;
  localparam int TLUL_DBW = TLUL_DW >> 3;
  localparam int TLUL_SZW = $clog2($clog2(TLUL_DBW) + 1);

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [TLUL_SZW-1:0] size;
    logic [TLUL_AIW-1:0] source;
    logic [TLUL_AW-1:0]  address;
    logic [TLUL_DBW-1:0] mask;
    logic [TLUL_DW-1:0]  data;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]          opcode;
    logic [2:0]          param;
    logic [TLUL_SZW-1:0] size;
    logic [TLUL_AIW-1:0] source;
    logic [TLUL_DIW-1:0] sink;
    logic [TLUL_DW-1:0]  data;
    logic                error;
  } tl_d_t;

endpackage

`default_nettype wire

// File: rtl/tlul_fifo.sv
// tlul_fifo: registered valid/ready FIFO with wrap-bit pointers; output is never
// fall-through, so data pushed in cycle N is first visible in cycle N+1 (rev 1.0).
`default_nettype none

module tlul_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Equal index with opposite wrap bits means the writer has lapped the reader.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready  = rstn && !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr[PW-1:0]];

  // Storage is cleared too so the payload outputs read zero straight after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= in_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tlul_buffered_bridge.sv
// tlul_buffered_bridge: TL-UL host-to-device bridge with registered A/D FIFOs
// and a limit on A beats issued to the device but not yet answered (rev 1.0).
`default_nettype none

module tlul_buffered_bridge
  import tlul_pkg::*;
#(
  parameter int TL_AW           = TLUL_AW,
  parameter int TL_DW           = TLUL_DW,
  parameter int TL_AIW          = TLUL_AIW,
  parameter int TL_DIW          = TLUL_DIW,
  parameter int TL_DBW          = TL_DW >> 3,
  parameter int TL_SZW          = $clog2($clog2(TL_DBW) + 1),
  parameter int A_DEPTH         = 2,
  parameter int D_DEPTH         = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rstn,

  input  logic              master_a_valid,
  output logic              master_a_ready,
  input  logic [2:0]        master_a_opcode,
  input  logic [2:0]        master_a_param,
  input  logic [TL_SZW-1:0] master_a_size,
  input  logic [TL_AIW-1:0] master_a_source,
  input  logic [TL_AW-1:0]  master_a_address,
  input  logic [TL_DBW-1:0] master_a_mask,
  input  logic [TL_DW-1:0]  master_a_data,

  output logic              master_d_valid,
  input  logic              master_d_ready,
  output logic [2:0]        master_d_opcode,
  output logic [2:0]        master_d_param,
  output logic [TL_SZW-1:0] master_d_size,
  output logic [TL_AIW-1:0] master_d_source,
  output logic [TL_DIW-1:0] master_d_sink,
  output logic [TL_DW-1:0]  master_d_data,
  output logic              master_d_error,

  output logic              slave_a_valid,
  input  logic              slave_a_ready,
  output logic [2:0]        slave_a_opcode,
  output logic [2:0]        slave_a_param,
  output logic [TL_SZW-1:0] slave_a_size,
  output logic [TL_AIW-1:0] slave_a_source,
  output logic [TL_AW-1:0]  slave_a_address,
  output logic [TL_DBW-1:0] slave_a_mask,
  output logic [TL_DW-1:0]  slave_a_data,

  input  logic              slave_d_valid,
  output logic              slave_d_ready,
  input  logic [2:0]        slave_d_opcode,
  input  logic [2:0]        slave_d_param,
  input  logic [TL_SZW-1:0] slave_d_size,
  input  logic [TL_AIW-1:0] slave_d_source,
  input  logic [TL_DIW-1:0] slave_d_sink,
  input  logic [TL_DW-1:0]  slave_d_data,
  input  logic              slave_d_error,

  output logic [CW-1:0]     outstanding,
  output logic              idle
);

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_AW-1:0]  address;
    logic [TL_DBW-1:0] mask;
    logic [TL_DW-1:0]  data;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [TL_SZW-1:0] size;
    logic [TL_AIW-1:0] source;
    logic [TL_DIW-1:0] sink;
    logic [TL_DW-1:0]  data;
    logic              error;
  } d_beat_t;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  a_beat_t       a_in;
  a_beat_t       a_out;
  d_beat_t       d_in;
  d_beat_t       d_out;
  logic          a_nonempty;
  logic          d_nonempty;
  logic          below_limit;
  logic          a_hs;
  logic          d_hs;
  logic [CW-1:0] cnt;

  assign a_in = '{opcode: master_a_opcode, param: master_a_param, size: master_a_size,
                  source: master_a_source, address: master_a_address,
                  mask: master_a_mask, data: master_a_data};

  assign d_in = '{opcode: slave_d_opcode, param: slave_d_param, size: slave_d_size,
                  source: slave_d_source, sink: slave_d_sink,
                  data: slave_d_data, error: slave_d_error};

  // The limiter only gates the FIFO output, so the head stays put until issued.
  assign below_limit   = (cnt < MAX_CNT);
  assign slave_a_valid = a_nonempty && below_limit;
  assign a_hs          = slave_a_valid && slave_a_ready;

  tlul_fifo #(
    .WIDTH ($bits(a_beat_t)),
    .DEPTH (A_DEPTH)
  ) u_a_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (master_a_valid),
    .in_ready  (master_a_ready),
    .in_data   (a_in),
    .out_valid (a_nonempty),
    .out_ready (slave_a_ready && below_limit),
    .out_data  (a_out)
  );

  assign slave_a_opcode  = a_out.opcode;
  assign slave_a_param   = a_out.param;
  assign slave_a_size    = a_out.size;
  assign slave_a_source  = a_out.source;
  assign slave_a_address = a_out.address;
  assign slave_a_mask    = a_out.mask;
  assign slave_a_data    = a_out.data;

  assign master_d_valid = d_nonempty;
  assign d_hs           = master_d_valid && master_d_ready;

  tlul_fifo #(
    .WIDTH ($bits(d_beat_t)),
    .DEPTH (D_DEPTH)
  ) u_d_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (slave_d_valid),
    .in_ready  (slave_d_ready),
    .in_data   (d_in),
    .out_valid (d_nonempty),
    .out_ready (master_d_ready),
    .out_data  (d_out)
  );

  assign master_d_opcode = d_out.opcode;
  assign master_d_param  = d_out.param;
  assign master_d_size   = d_out.size;
  assign master_d_source = d_out.source;
  assign master_d_sink   = d_out.sink;
  assign master_d_data   = d_out.data;
  assign master_d_error  = d_out.error;

  // A stray response at zero leaves the count pinned at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (a_hs && !d_hs) begin
      cnt <= cnt + CW'(1);
    end else if (d_hs && !a_hs && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (cnt <= MAX_CNT);
      assert (!(d_hs && (cnt == '0)));
    end
  end

  assign outstanding = cnt;
  assign idle        = !a_nonempty && !d_nonempty && (cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_tlul_buffered_bridge.sv
// tb_tlul_buffered_bridge: directed checks of the buffered TL-UL bridge plus a
// back-to-back scoreboard run (rev 1.0).
`default_nettype none

module tb_tlul_buffered_bridge;
  import tlul_pkg::*;

  logic        clk;
  logic        rstn;
  logic        master_a_valid, master_a_ready;
  logic [2:0]  master_a_opcode, master_a_param;
  logic [1:0]  master_a_size;
  logic [7:0]  master_a_source;
  logic [31:0] master_a_address;
  logic [3:0]  master_a_mask;
  logic [31:0] master_a_data;
  logic        master_d_valid, master_d_ready;
  logic [2:0]  master_d_opcode, master_d_param;
  logic [1:0]  master_d_size;
  logic [7:0]  master_d_source;
  logic [0:0]  master_d_sink;
  logic [31:0] master_d_data;
  logic        master_d_error;
  logic        slave_a_valid, slave_a_ready;
  logic [2:0]  slave_a_opcode, slave_a_param;
  logic [1:0]  slave_a_size;
  logic [7:0]  slave_a_source;
  logic [31:0] slave_a_address;
  logic [3:0]  slave_a_mask;
  logic [31:0] slave_a_data;
  logic        slave_d_valid, slave_d_ready;
  logic [2:0]  slave_d_opcode, slave_d_param;
  logic [1:0]  slave_d_size;
  logic [7:0]  slave_d_source;
  logic [0:0]  slave_d_sink;
  logic [31:0] slave_d_data;
  logic        slave_d_error;
  logic [2:0]  outstanding;
  logic        idle;

  int tests = 0;
  int fails = 0;
  int a_hs_total = 0;

  tlul_buffered_bridge dut (
    .clk(clk), .rstn(rstn),
    .master_a_valid(master_a_valid), .master_a_ready(master_a_ready),
    .master_a_opcode(master_a_opcode), .master_a_param(master_a_param),
    .master_a_size(master_a_size), .master_a_source(master_a_source),
    .master_a_address(master_a_address), .master_a_mask(master_a_mask),
    .master_a_data(master_a_data),
    .master_d_valid(master_d_valid), .master_d_ready(master_d_ready),
    .master_d_opcode(master_d_opcode), .master_d_param(master_d_param),
    .master_d_size(master_d_size), .master_d_source(master_d_source),
    .master_d_sink(master_d_sink), .master_d_data(master_d_data),
    .master_d_error(master_d_error),
    .slave_a_valid(slave_a_valid), .slave_a_ready(slave_a_ready),
    .slave_a_opcode(slave_a_opcode), .slave_a_param(slave_a_param),
    .slave_a_size(slave_a_size), .slave_a_source(slave_a_source),
    .slave_a_address(slave_a_address), .slave_a_mask(slave_a_mask),
    .slave_a_data(slave_a_data),
    .slave_d_valid(slave_d_valid), .slave_d_ready(slave_d_ready),
    .slave_d_opcode(slave_d_opcode), .slave_d_param(slave_d_param),
    .slave_d_size(slave_d_size), .slave_d_source(slave_d_source),
    .slave_d_sink(slave_d_sink), .slave_d_data(slave_d_data),
    .slave_d_error(slave_d_error),
    .outstanding(outstanding), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshakes are counted mid-cycle, once inputs are settled for the next edge.
  always @(negedge clk) begin
    if (rstn && slave_a_valid && slave_a_ready) a_hs_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [7:0] src,
                         input logic [31:0] addr, input logic [31:0] dat);
    master_a_valid   = 1'b1;
    master_a_opcode  = op;
    master_a_param   = 3'd0;
    master_a_size    = 2'd2;
    master_a_source  = src;
    master_a_address = addr;
    master_a_mask    = 4'hF;
    master_a_data    = dat;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [7:0] src,
                         input logic [31:0] dat, input logic err);
    slave_d_valid  = 1'b1;
    slave_d_opcode = op;
    slave_d_param  = 3'd0;
    slave_d_size   = 2'd2;
    slave_d_source = src;
    slave_d_sink   = 1'b0;
    slave_d_data   = dat;
    slave_d_error  = err;
  endtask

  tl_a_t qa[$];
  tl_d_t qd[$];

  initial begin
    int    hs0;
    int    a_seen, d_seen, a_bad, d_bad, stalls;
    int    a_first, a_last, d_first, d_last;
    logic  pend_v, next_v;
    tl_d_t pend, nxt, dobs;
    tl_a_t abeat, aobs;

    rstn = 1'b0;
    master_a_valid = 0; master_a_opcode = 0; master_a_param = 0; master_a_size = 0;
    master_a_source = 0; master_a_address = 0; master_a_mask = 0; master_a_data = 0;
    master_d_ready = 0; slave_a_ready = 0;
    slave_d_valid = 0; slave_d_opcode = 0; slave_d_param = 0; slave_d_size = 0;
    slave_d_source = 0; slave_d_sink = 0; slave_d_data = 0; slave_d_error = 0;

    tick(); tick();
    chk("rst_slave_a_valid", slave_a_valid, 0);
    chk("rst_master_d_valid", master_d_valid, 0);
    chk("rst_master_a_ready", master_a_ready, 0);
    chk("rst_slave_d_ready", slave_d_ready, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_idle", idle, 1);
    chk("rst_slave_a_address", slave_a_address, 0);
    chk("rst_master_d_data", master_d_data, 0);
    rstn = 1'b1;
    #1;
    chk("run_master_a_ready", master_a_ready, 1);
    chk("run_slave_d_ready", slave_d_ready, 1);

    // Single Get, then its AccessAckData
    drive_a(Get, 8'h05, 32'h1000, 32'h0);
    #1;
    chk("get_accept", master_a_ready, 1);
    chk("get_not_fallthrough", slave_a_valid, 0);
    tick();
    master_a_valid = 0;
    #1;
    chk("get_slave_valid", slave_a_valid, 1);
    chk("get_slave_addr", slave_a_address, 32'h1000);
    chk("get_slave_source", slave_a_source, 8'h05);
    chk("get_slave_opcode", slave_a_opcode, Get);
    chk("get_outst_before", outstanding, 0);
    chk("get_not_idle", idle, 0);
    slave_a_ready = 1;
    tick();
    slave_a_ready = 0;
    #1;
    chk("get_outst_1", outstanding, 1);
    chk("get_slave_valid_drop", slave_a_valid, 0);
    drive_d(AccessAckData, 8'h05, 32'hDEADBEEF, 1'b0);
    #1;
    chk("ack_not_fallthrough", master_d_valid, 0);
    tick();
    slave_d_valid = 0;
    #1;
    chk("ack_master_valid", master_d_valid, 1);
    chk("ack_master_data", master_d_data, 32'hDEADBEEF);
    chk("ack_master_source", master_d_source, 8'h05);
    chk("ack_master_opcode", master_d_opcode, AccessAckData);
    master_d_ready = 1;
    tick();
    master_d_ready = 0;
    #1;
    chk("ack_master_valid_drop", master_d_valid, 0);
    chk("ack_outst_0", outstanding, 0);
    chk("ack_idle", idle, 1);

    // A FIFO fills under device back-pressure
    drive_a(PutFullData, 8'h01, 32'h100, 32'h11);
    #1;
    chk("bp_accept_1", master_a_ready, 1);
    tick();
    drive_a(PutFullData, 8'h02, 32'h104, 32'h22);
    #1;
    chk("bp_accept_2", master_a_ready, 1);
    tick();
    drive_a(PutFullData, 8'h03, 32'h108, 32'h33);
    #1;
    chk("bp_full_ready", master_a_ready, 0);
    chk("bp_head_addr", slave_a_address, 32'h100);
    tick();
    #1;
    chk("bp_full_ready_hold", master_a_ready, 0);
    chk("bp_head_addr_stable", slave_a_address, 32'h100);
    chk("bp_head_data_stable", slave_a_data, 32'h11);
    slave_a_ready = 1;
    tick();
    #1;
    chk("bp_second_addr", slave_a_address, 32'h104);
    chk("bp_ready_again", master_a_ready, 1);
    tick();
    master_a_valid = 0;
    #1;
    chk("bp_third_addr", slave_a_address, 32'h108);
    chk("bp_third_data", slave_a_data, 32'h33);
    chk("bp_outst_2", outstanding, 2);
    tick();
    slave_a_ready = 0;
    #1;
    chk("bp_outst_3", outstanding, 3);
    chk("bp_a_empty", slave_a_valid, 0);

    master_d_ready = 1;
    drive_d(AccessAck, 8'h01, 32'h1, 1'b0);
    tick();
    drive_d(AccessAck, 8'h02, 32'h2, 1'b0);
    #1;
    chk("drain_d1", master_d_data, 32'h1);
    tick();
    drive_d(AccessAck, 8'h03, 32'h3, 1'b0);
    #1;
    chk("drain_d2", master_d_data, 32'h2);
    chk("drain_outst_2", outstanding, 2);
    tick();
    slave_d_valid = 0;
    tick();
    #1;
    chk("drain_outst_0", outstanding, 0);
    chk("drain_idle", idle, 1);

    // Outstanding limit: six Puts, no responses
    slave_a_ready = 1;
    hs0 = a_hs_total;
    for (int i = 0; i < 6; i++) begin
      drive_a(PutFullData, 8'h10, 32'h200 + 32'(4 * i), 32'(i));
      #1;
      chk("lim_accept", master_a_ready, 1);
      tick();
    end
    master_a_valid = 0;
    tick(); tick();
    #1;
    chk("lim_hs_count", a_hs_total - hs0, 4);
    chk("lim_valid_low", slave_a_valid, 0);
    chk("lim_outst_4", outstanding, 4);
    chk("lim_head_addr", slave_a_address, 32'h210);
    chk("lim_a_full", master_a_ready, 0);
    drive_d(AccessAck, 8'h10, 32'hAA, 1'b0);
    tick();
    slave_d_valid = 0;
    #1;
    chk("lim_d_valid", master_d_valid, 1);
    chk("lim_still_blocked", slave_a_valid, 0);
    tick();
    #1;
    chk("lim_outst_3", outstanding, 3);
    chk("lim_fifth_valid", slave_a_valid, 1);
    chk("lim_fifth_addr", slave_a_address, 32'h210);
    tick();
    slave_a_ready = 0;
    #1;
    chk("lim_fifth_issued", outstanding, 4);
    chk("lim_sixth_addr", slave_a_address, 32'h214);

    // Same-cycle A issue and D return at outstanding 2
    drive_d(AccessAck, 8'h10, 32'hB1, 1'b0);
    tick();
    drive_d(AccessAck, 8'h10, 32'hB2, 1'b0);
    tick();
    slave_d_valid = 0;
    tick();
    #1;
    chk("same_pre_outst", outstanding, 2);
    chk("same_pre_a_valid", slave_a_valid, 1);
    master_d_ready = 0;
    drive_d(AccessAck, 8'h10, 32'hB3, 1'b0);
    tick();
    slave_d_valid = 0;
    #1;
    chk("same_d_valid", master_d_valid, 1);
    chk("same_outst_2a", outstanding, 2);
    slave_a_ready = 1;
    master_d_ready = 1;
    tick();
    slave_a_ready = 0;
    master_d_ready = 0;
    #1;
    chk("same_outst_2b", outstanding, 2);
    chk("same_a_drained", slave_a_valid, 0);
    chk("same_d_drained", master_d_valid, 0);

    // Mid-traffic reset with two A beats queued and three outstanding
    slave_a_ready = 1;
    drive_a(PutFullData, 8'h20, 32'h300, 32'hC0);
    tick();
    drive_a(PutFullData, 8'h21, 32'h304, 32'hC1);
    tick();
    drive_a(PutFullData, 8'h22, 32'h308, 32'hC2);
    slave_a_ready = 0;
    drive_d(AccessAck, 8'h20, 32'hC1, 1'b0);
    tick();
    master_a_valid = 0;
    slave_d_valid = 0;
    #1;
    chk("mrst_pre_outst", outstanding, 3);
    chk("mrst_pre_a_full", master_a_ready, 0);
    chk("mrst_pre_d_valid", master_d_valid, 1);
    rstn = 0;
    slave_a_ready = 1;
    master_d_ready = 1;
    #1;
    chk("mrst_comb_ready", master_a_ready, 0);
    tick();
    #1;
    chk("mrst_slave_a_valid", slave_a_valid, 0);
    chk("mrst_master_d_valid", master_d_valid, 0);
    chk("mrst_master_a_ready", master_a_ready, 0);
    chk("mrst_slave_d_ready", slave_d_ready, 0);
    chk("mrst_outst", outstanding, 0);
    chk("mrst_idle", idle, 1);
    rstn = 1;
    hs0 = a_hs_total;
    #1;
    chk("mrst_release_ready", master_a_ready, 1);
    tick(); tick();
    #1;
    chk("mrst_no_stale_hs", a_hs_total - hs0, 0);
    chk("mrst_no_stale_a", slave_a_valid, 0);
    chk("mrst_no_stale_d", master_d_valid, 0);
    chk("mrst_idle_after", idle, 1);

    // 64 back-to-back random beats with an echoing device model
    slave_a_ready = 1;
    master_d_ready = 1;
    a_seen = 0; d_seen = 0; a_bad = 0; d_bad = 0; stalls = 0;
    a_first = -1; a_last = -1; d_first = -1; d_last = -1;
    pend_v = 0;
    pend = '0;
    for (int i = 0; i < 72; i++) begin
      if (i < 64) begin
        drive_a($urandom_range(0, 1) ? Get : PutFullData, 8'($urandom),
                $urandom & 32'hFFFF_FFFC, $urandom);
      end else begin
        master_a_valid = 0;
      end
      if (pend_v) drive_d(pend.opcode, pend.source, pend.data, pend.error);
      else slave_d_valid = 0;
      #1;
      if (master_a_valid && master_a_ready) begin
        abeat = '{opcode: master_a_opcode, param: master_a_param, size: master_a_size,
                  source: master_a_source, address: master_a_address,
                  mask: master_a_mask, data: master_a_data};
        qa.push_back(abeat);
      end
      if (master_a_valid && !master_a_ready) stalls++;
      next_v = 0;
      nxt = '0;
      if (slave_a_valid && slave_a_ready) begin
        aobs = '{opcode: slave_a_opcode, param: slave_a_param, size: slave_a_size,
                 source: slave_a_source, address: slave_a_address,
                 mask: slave_a_mask, data: slave_a_data};
        if (qa.size() == 0) a_bad++;
        else begin
          abeat = qa.pop_front();
          if (aobs !== abeat) a_bad++;
        end
        a_seen++;
        if (a_first < 0) a_first = i;
        a_last = i;
        next_v = 1;
        nxt.opcode = (aobs.opcode == Get) ? AccessAckData : AccessAck;
        nxt.size   = aobs.size;
        nxt.source = aobs.source;
        nxt.data   = (aobs.opcode == Get) ? ~aobs.data : 32'h0;
        nxt.error  = aobs.address[2];
      end
      if (slave_d_valid && slave_d_ready) qd.push_back(pend);
      if (slave_d_valid && !slave_d_ready) stalls++;
      if (master_d_valid && master_d_ready) begin
        dobs = '{opcode: master_d_opcode, param: master_d_param, size: master_d_size,
                 source: master_d_source, sink: master_d_sink,
                 data: master_d_data, error: master_d_error};
        if (qd.size() == 0) d_bad++;
        else if (dobs !== qd.pop_front()) d_bad++;
        d_seen++;
        if (d_first < 0) d_first = i;
        d_last = i;
      end
      tick();
      pend_v = next_v;
      pend = nxt;
    end
    slave_d_valid = 0;
    #1;
    chk("rand_a_count", a_seen, 64);
    chk("rand_d_count", d_seen, 64);
    chk("rand_a_payload", a_bad, 0);
    chk("rand_d_payload", d_bad, 0);
    chk("rand_stalls", stalls, 0);
    chk("rand_a_rate", a_last - a_first, 63);
    chk("rand_d_rate", d_last - d_first, 63);
    chk("rand_outst_0", outstanding, 0);
    chk("rand_idle", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
